// File: rtl/sum_sched_pkg.sv
// Shared types and constants for the series-sum scheduler and its arbiter.
package sum_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_e;

    localparam int CNT_W = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sum_rr_arb.sv
// Round-robin arbiter: first active request at or after ptr, ascending with wrap.
module sum_rr_arb
    import sum_sched_pkg::*;
#(
    parameter int NOF_REQ = 4,
    parameter int ID_W    = id_width(NOF_REQ)
) (
    input  logic [NOF_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NOF_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0] cand_s;

    // Rotating priority search; the first hit latches and later hits are masked.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        for (int i = 0; i < NOF_REQ; i++) begin
            cand_s = ID_W'((int'(ptr) + i) % NOF_REQ);
            if (!grant_valid && req[cand_s]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
        grant[grant_idx] = grant_valid;
    end

endmodule

// File: rtl/sum_scheduler.sv
// Arbitrates between requesters, sums one series of beats from the winner and
// presents the sum, beat count and owner id as a held result.
module sum_scheduler
    import sum_sched_pkg::*;
#(
    parameter  int NOF_BITS = 32,
    parameter  int NOF_REQ  = 4,
    localparam int ID_W     = id_width(NOF_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NOF_REQ-1:0]          in_valid,
    input  logic [NOF_REQ-1:0]          in_first,
    input  logic [NOF_REQ-1:0]          in_last,
    input  logic [NOF_REQ*NOF_BITS-1:0] in_data,
    output logic [NOF_REQ-1:0]          in_ready,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [NOF_BITS:0]           res_data,
    output logic [ID_W-1:0]             res_id,
    output logic [CNT_W-1:0]            res_cnt,
    output logic                        busy
);

    state_e              state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     gnt_r;
    logic [NOF_BITS:0]   sum_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NOF_REQ-1:0]  in_ready_r;
    logic                res_valid_r;
    logic [NOF_BITS:0]   res_data_r;
    logic [ID_W-1:0]     res_id_r;
    logic [CNT_W-1:0]    res_cnt_r;
    logic                busy_r;

    logic [NOF_REQ-1:0]  req_s;
    logic [NOF_REQ-1:0]  arb_grant_s;
    logic [ID_W-1:0]     arb_idx_s;
    logic                arb_valid_s;
    logic [NOF_BITS-1:0] beat_data_s;
    logic                xfer_s;
    logic [NOF_BITS:0]   sum_nxt_s;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [ID_W-1:0]     ptr_nxt_s;

    assign req_s       = in_valid & in_first;
    assign beat_data_s = in_data[gnt_r*NOF_BITS +: NOF_BITS];
    assign xfer_s      = in_valid[gnt_r] & in_ready_r[gnt_r];

    sum_rr_arb #(
        .NOF_REQ (NOF_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req_s),
        .ptr         (ptr_r),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Next accumulator values for the granted requester's current beat.
    always_comb begin
        sum_nxt_s = sum_r;
        cnt_nxt_s = cnt_r;
        if (in_first[gnt_r]) begin
            sum_nxt_s = {1'b0, beat_data_s};
            cnt_nxt_s = CNT_W'(1);
        end else begin
            sum_nxt_s = sum_r + {1'b0, beat_data_s};
            if (cnt_r == {CNT_W{1'b1}}) begin
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        ptr_nxt_s = '0;
        if (gnt_r == ID_W'(NOF_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_r + ID_W'(1);
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            gnt_r       <= '0;
            sum_r       <= '0;
            cnt_r       <= '0;
            in_ready_r  <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_id_r    <= '0;
            res_cnt_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arb_valid_s) begin
                        gnt_r      <= arb_idx_s;
                        in_ready_r <= arb_grant_s;
                        busy_r     <= 1'b1;
                        state_r    <= ACCUM;
                    end else begin
                        in_ready_r <= '0;
                        busy_r     <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (xfer_s) begin
                        sum_r <= sum_nxt_s;
                        cnt_r <= cnt_nxt_s;
                        if (in_last[gnt_r]) begin
                            res_data_r  <= sum_nxt_s;
                            res_cnt_r   <= cnt_nxt_s;
                            res_id_r    <= gnt_r;
                            res_valid_r <= 1'b1;
                            in_ready_r  <= '0;
                            state_r     <= RESULT;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        ptr_r       <= ptr_nxt_s;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESULT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= '0;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;
    assign res_cnt   = res_cnt_r;
    assign busy      = busy_r;

endmodule
